// File: rtl/ball_engine_if.sv
// Signal bundle between the ball engine (slave) and the scan/paddle/score logic (master).
`timescale 1ns/1ps
interface ball_engine_if;
    logic [5:0] counter_x;
    logic [5:0] counter_y;
    logic [5:0] paddle_l_y;
    logic [5:0] paddle_r_y;
    logic [5:0] ball_x;
    logic [5:0] ball_y;
    logic       draw_ball;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       point_l;
    logic       point_r;
    logic       game_over;

    modport master (
        output counter_x, counter_y, paddle_l_y, paddle_r_y,
        input  ball_x, ball_y, draw_ball, score_l, score_r, point_l, point_r, game_over
    );

    modport slave (
        input  counter_x, counter_y, paddle_l_y, paddle_r_y,
        output ball_x, ball_y, draw_ball, score_l, score_r, point_l, point_r, game_over
    );
endinterface

// File: rtl/ball_engine.sv
// Pong ball: position, wall/paddle bounces, scoring and registered pixel flag on a 64x64 grid.
// Optional BALL_SPEEDUP_EN shortens the step period on each paddle hit.
`timescale 1ns/1ps
module ball_engine #(
    parameter int LEFT_PADDLE_X  = 2,
    parameter int RIGHT_PADDLE_X = 60,
    parameter int PADDLE_HEIGHT  = 6,
    parameter int TOP_WALL       = 6,
    parameter int BOTTOM_WALL    = 28,
    parameter int CENTER_X       = 32,
    parameter int CENTER_Y       = 17,
    parameter int BALL_SPEED     = 100,
    parameter int SERVE_DELAY    = 8,
    parameter int WIN_SCORE      = 7
) (
    input  logic         clk,
    input  logic         rst,
    ball_engine_if.slave bus
);
    localparam int CW = (BALL_SPEED < 1) ? 1 : $clog2(BALL_SPEED + 1);
    localparam int SW = (SERVE_DELAY < 2) ? 1 : $clog2(SERVE_DELAY);

    localparam logic [CW-1:0] SPEED_MAX  = CW'(BALL_SPEED);
    localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_DELAY - 1);
    localparam logic [5:0]    CX         = 6'(CENTER_X);
    localparam logic [5:0]    CY         = 6'(CENTER_Y);
    localparam logic [5:0]    TOP        = 6'(TOP_WALL);
    localparam logic [5:0]    BOT        = 6'(BOTTOM_WALL);
    localparam logic [5:0]    L_FACE     = 6'(LEFT_PADDLE_X + 2);
    localparam logic [5:0]    R_FACE     = 6'(RIGHT_PADDLE_X - 1);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

    typedef enum logic [1:0] {
        SERVE     = 2'd0,
        MOVE      = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    state_t        r_state;
    logic [5:0]    r_ball_x;
    logic [5:0]    r_ball_y;
    logic          r_dx_neg;
    logic          r_dy_neg;
    logic [CW-1:0] r_speed_cnt;
    logic [SW-1:0] r_serve_cnt;
    logic [3:0]    r_score_l;
    logic [3:0]    r_score_r;
    logic          r_point_l;
    logic          r_point_r;
    logic          r_draw_ball;
    logic          r_game_over;

    logic          w_tick;
    logic          w_left_face;
    logic          w_right_face;
    logic          w_l_hit;
    logic          w_r_hit;
    logic [3:0]    w_score_l_inc;
    logic [3:0]    w_score_r_inc;

    assign w_left_face  = r_dx_neg  && (r_ball_x == L_FACE);
    assign w_right_face = !r_dx_neg && (r_ball_x == R_FACE);

    // Paddle span is compared in 7 bits so paddle_y+PADDLE_HEIGHT cannot wrap past row 63.
    assign w_l_hit = ({1'b0, r_ball_y} >= {1'b0, bus.paddle_l_y}) &&
                     ({1'b0, r_ball_y} <= ({1'b0, bus.paddle_l_y} + 7'(PADDLE_HEIGHT)));
    assign w_r_hit = ({1'b0, r_ball_y} >= {1'b0, bus.paddle_r_y}) &&
                     ({1'b0, r_ball_y} <= ({1'b0, bus.paddle_r_y} + 7'(PADDLE_HEIGHT)));

    assign w_score_l_inc = (r_score_l >= WIN) ? WIN : r_score_l + 4'd1;
    assign w_score_r_inc = (r_score_r >= WIN) ? WIN : r_score_r + 4'd1;

`ifdef BALL_SPEEDUP_EN
    logic [CW-1:0] r_period;
    logic          w_hit;
    logic          w_to_serve;

    assign w_tick     = (r_speed_cnt >= r_period);
    assign w_hit      = w_tick && (r_state == MOVE) &&
                        ((w_left_face && w_l_hit) || (w_right_face && w_r_hit));
    assign w_to_serve = w_tick && (r_state == MOVE) &&
                        ((w_left_face && !w_l_hit && (w_score_r_inc != WIN)) ||
                         (w_right_face && !w_r_hit && (w_score_l_inc != WIN)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_period <= SPEED_MAX;
        end else if (w_to_serve) begin
            r_period <= SPEED_MAX;
        end else if (w_hit) begin
            if (int'(r_period) >= 24)
                r_period <= r_period - CW'(8);
            else if (int'(r_period) > 16)
                r_period <= CW'(16);
        end
    end
`else
    assign w_tick = (r_speed_cnt == SPEED_MAX);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= SERVE;
            r_ball_x    <= CX;
            r_ball_y    <= CY;
            r_dx_neg    <= 1'b0;
            r_dy_neg    <= 1'b0;
            r_speed_cnt <= '0;
            r_serve_cnt <= '0;
            r_score_l   <= 4'd0;
            r_score_r   <= 4'd0;
            r_point_l   <= 1'b0;
            r_point_r   <= 1'b0;
            r_draw_ball <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_point_l   <= 1'b0;
            r_point_r   <= 1'b0;
            r_draw_ball <= (bus.counter_x == r_ball_x) && (bus.counter_y == r_ball_y) &&
                           (r_state != GAME_OVER);
            r_speed_cnt <= w_tick ? '0 : r_speed_cnt + 1'b1;
            if (w_tick) begin
                case (r_state)
                    SERVE: begin
                        if (r_serve_cnt == SERVE_LAST) begin
                            r_serve_cnt <= '0;
                            r_state     <= MOVE;
                        end else begin
                            r_serve_cnt <= r_serve_cnt + 1'b1;
                        end
                    end
                    MOVE: begin
                        if (!r_dy_neg && (r_ball_y == BOT)) begin
                            r_dy_neg <= 1'b1;
                            r_ball_y <= r_ball_y - 6'd1;
                        end else if (r_dy_neg && (r_ball_y == TOP)) begin
                            r_dy_neg <= 1'b0;
                            r_ball_y <= r_ball_y + 6'd1;
                        end else begin
                            r_ball_y <= r_dy_neg ? r_ball_y - 6'd1 : r_ball_y + 6'd1;
                        end
                        // A miss re-centres the ball and overrides the Y step above.
                        if (w_left_face && w_l_hit) begin
                            r_dx_neg <= 1'b0;
                            r_ball_x <= r_ball_x + 6'd1;
                        end else if (w_right_face && w_r_hit) begin
                            r_dx_neg <= 1'b1;
                            r_ball_x <= r_ball_x - 6'd1;
                        end else if (w_left_face) begin
                            r_score_r <= w_score_r_inc;
                            r_point_r <= 1'b1;
                            r_dx_neg  <= 1'b1;
                            r_dy_neg  <= 1'b0;
                            r_ball_x  <= CX;
                            r_ball_y  <= CY;
                            r_state     <= (w_score_r_inc == WIN) ? GAME_OVER : SERVE;
                            r_game_over <= (w_score_r_inc == WIN);
                        end else if (w_right_face) begin
                            r_score_l <= w_score_l_inc;
                            r_point_l <= 1'b1;
                            r_dx_neg  <= 1'b0;
                            r_dy_neg  <= 1'b0;
                            r_ball_x  <= CX;
                            r_ball_y  <= CY;
                            r_state     <= (w_score_l_inc == WIN) ? GAME_OVER : SERVE;
                            r_game_over <= (w_score_l_inc == WIN);
                        end else begin
                            r_ball_x <= r_dx_neg ? r_ball_x - 6'd1 : r_ball_x + 6'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.ball_x    = r_ball_x;
    assign bus.ball_y    = r_ball_y;
    assign bus.draw_ball = r_draw_ball;
    assign bus.score_l   = r_score_l;
    assign bus.score_r   = r_score_r;
    assign bus.point_l   = r_point_l;
    assign bus.point_r   = r_point_r;
    assign bus.game_over = r_game_over;
endmodule

// File: tb/tb_ball_engine.sv
// Directed rallies for ball_engine (BALL_SPEED=3, SERVE_DELAY=2) with a queue of expected ball moves.
`timescale 1ns/1ps
module tb_ball_engine;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ball_engine_if bus();

    ball_engine #(
        .BALL_SPEED  (3),
        .SERVE_DELAY (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [5:0] x;
        logic [5:0] y;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       pl;
        logic       pr;
        logic       go;
    } ev_t;

    ev_t        exp_q[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [3:0] exp_sl = 4'd0;
    logic [3:0] exp_sr = 4'd0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_ev(input int x, input int y, input logic pl, input logic pr, input logic go);
        ev_t e;
        e.x  = 6'(x);
        e.y  = 6'(y);
        e.sl = exp_sl;
        e.sr = exp_sr;
        e.pl = pl;
        e.pr = pr;
        e.go = go;
        exp_q.push_back(e);
    endtask

    // n consecutive ball positions starting at (x0,y0), stepping (sx,sy) per tick
    task automatic push_seg(input int x0, input int y0, input int sx, input int sy, input int n);
        for (int i = 0; i < n; i++)
            push_ev(x0 + i * sx, y0 + i * sy, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_arrive(input int x, input int y, output int cyc);
        bit left;
        left = 1'b0;
        cyc  = 0;
        forever begin
            if (int'(bus.ball_x) != x || int'(bus.ball_y) != y) left = 1'b1;
            else if (left) return;
            if (cyc >= 1500) begin
                n_cmp++;
                n_fail++;
                $display("FAIL wait_arrive(%0d,%0d): timeout, ball=(%0d,%0d)", x, y, bus.ball_x, bus.ball_y);
                return;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Monitor: every change of ball position pops one expected event.
    logic [5:0] mon_x, mon_y;
    logic       mon_pl, mon_pr;
    ev_t        mon_e;

    always @(negedge clk) begin
        if (!rst) begin
            mon_x  = bus.ball_x;
            mon_y  = bus.ball_y;
            mon_pl = 1'b0;
            mon_pr = 1'b0;
        end else begin
            if (mon_pl) check("point_l_width", bus.point_l, 0);
            if (mon_pr) check("point_r_width", bus.point_r, 0);
            if (bus.point_l || bus.point_r)
                check("point_exclusive", bus.point_l & bus.point_r, 0);
            if (bus.ball_x != mon_x || bus.ball_y != mon_y) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_move: ball=(%0d,%0d), no move expected", bus.ball_x, bus.ball_y);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.ball_x != mon_e.x || bus.ball_y != mon_e.y ||
                        bus.score_l != mon_e.sl || bus.score_r != mon_e.sr ||
                        bus.point_l != mon_e.pl || bus.point_r != mon_e.pr ||
                        bus.game_over != mon_e.go) begin
                        n_fail++;
                        $display("FAIL move_event: got (%0d,%0d) sl=%0d sr=%0d pl=%0d pr=%0d go=%0d, expected (%0d,%0d) sl=%0d sr=%0d pl=%0d pr=%0d go=%0d",
                                 bus.ball_x, bus.ball_y, bus.score_l, bus.score_r, bus.point_l, bus.point_r, bus.game_over,
                                 mon_e.x, mon_e.y, mon_e.sl, mon_e.sr, mon_e.pl, mon_e.pr, mon_e.go);
                    end
                end
            end
            mon_x  = bus.ball_x;
            mon_y  = bus.ball_y;
            mon_pl = bus.point_l;
            mon_pr = bus.point_r;
        end
    end

    task automatic push_rally_to_right;
        push_seg(33, 18, 1, 1, 11);
        push_seg(44, 27, 1, -1, 16);
    endtask

    task automatic push_right_to_left;
        push_seg(58, 11, -1, -1, 6);
        push_seg(52, 7, -1, 1, 22);
        push_seg(30, 27, -1, -1, 22);
        push_seg(8, 7, -1, 1, 5);
    endtask

    initial begin
        int cyc;
        rst            = 1'b1;
        bus.counter_x  = 6'd0;
        bus.counter_y  = 6'd0;
        bus.paddle_l_y = 6'd0;
        bus.paddle_r_y = 6'd0;
        #2 rst = 1'b0;
        #1;
        check("rst_ball_x", bus.ball_x, 32);
        check("rst_ball_y", bus.ball_y, 17);
        check("rst_score_l", bus.score_l, 0);
        check("rst_score_r", bus.score_r, 0);
        check("rst_points", {bus.point_l, bus.point_r}, 0);
        check("rst_draw", bus.draw_ball, 0);
        check("rst_game_over", bus.game_over, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;

        // draw_ball while serving at centre
        @(posedge clk); #1;
        check("draw_idle", bus.draw_ball, 0);
        bus.counter_x = 6'd32; bus.counter_y = 6'd17;
        @(posedge clk); #1;
        check("draw_hit", bus.draw_ball, 1);
        bus.counter_x = 6'd33; bus.counter_y = 6'd17;
        @(posedge clk); #1;
        check("draw_neighbour", bus.draw_ball, 0);
        bus.counter_x = 6'd0; bus.counter_y = 6'd0;

        // Rally 1: bottom bounce, right edge-row hit, top bounce, left edge-row hit, right miss
        push_rally_to_right();
        wait_arrive(33, 18, cyc);
        check("first_move_cycles", cyc + 3, 12);
        wait_arrive(59, 12, cyc);
        bus.paddle_r_y = 6'd6;
        push_right_to_left();
        wait_arrive(4, 11, cyc);
        bus.paddle_l_y = 6'd11;
        push_seg(5, 12, 1, 1, 17);
        push_seg(22, 27, 1, -1, 22);
        push_seg(44, 7, 1, 1, 16);
        wait_arrive(59, 22, cyc);
        bus.paddle_r_y = 6'd23;
        exp_sl = 4'd1;
        push_ev(32, 17, 1'b1, 1'b0, 1'b0);

        // Rally 2: right mid hit, left miss
        push_rally_to_right();
        wait_arrive(59, 12, cyc);
        bus.paddle_r_y = 6'd10;
        push_right_to_left();
        wait_arrive(4, 11, cyc);
        bus.paddle_l_y = 6'd4;
        exp_sr = 4'd1;
        push_ev(32, 17, 1'b0, 1'b1, 1'b0);

        // Rally 3: serve leftward, left hit, right miss
        push_seg(31, 18, -1, 1, 11);
        push_seg(20, 27, -1, -1, 17);
        wait_arrive(4, 11, cyc);
        bus.paddle_l_y = 6'd8;
        push_seg(5, 10, 1, -1, 5);
        push_seg(10, 7, 1, 1, 22);
        push_seg(32, 27, 1, -1, 22);
        push_seg(54, 7, 1, 1, 6);
        wait_arrive(59, 12, cyc);
        bus.paddle_r_y = 6'd0;
        exp_sl = 4'd2;
        push_ev(32, 17, 1'b1, 1'b0, 1'b0);

        // Right misses until the left player reaches 7
        for (int s = 3; s <= 7; s++) begin
            push_rally_to_right();
            wait_arrive(59, 12, cyc);
            bus.paddle_r_y = 6'd20;
            exp_sl = 4'(s);
            push_ev(32, 17, 1'b1, 1'b0, s == 7);
        end

        cyc = 0;
        while (!bus.game_over && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("game_over", bus.game_over, 1);
        check("final_score_l", bus.score_l, 7);
        check("final_score_r", bus.score_r, 1);

        // 20 ticks frozen; draw_ball stays low even over the ball pixel
        for (int i = 0; i < 80; i++) begin
            bus.counter_x = 6'(30 + i % 5);
            bus.counter_y = 6'(15 + (i / 5) % 5);
            @(posedge clk); #1;
            check("draw_game_over", bus.draw_ball, 0);
        end
        check("frozen_ball_x", bus.ball_x, 32);
        check("frozen_ball_y", bus.ball_y, 17);
        check("game_over_held", bus.game_over, 1);

        // Asynchronous reset out of GAME_OVER
        #2 rst = 1'b0;
        #1;
        check("areset_score_l", bus.score_l, 0);
        check("areset_game_over", bus.game_over, 0);
        bus.counter_x = 6'd0; bus.counter_y = 6'd0;
        exp_sl = 4'd0;
        exp_sr = 4'd0;
        @(posedge clk);
        #2 rst = 1'b1;

        // Asynchronous reset mid-MOVE
        push_ev(33, 18, 1'b0, 1'b0, 1'b0);
        wait_arrive(33, 18, cyc);
        bus.counter_x = 6'd33; bus.counter_y = 6'd18;
        @(posedge clk); #1;
        check("draw_moving", bus.draw_ball, 1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_ball_x", bus.ball_x, 32);
        check("mid_rst_ball_y", bus.ball_y, 17);
        check("mid_rst_draw", bus.draw_ball, 0);
        check("mid_rst_points", {bus.point_l, bus.point_r}, 0);
        check("mid_rst_scores", {bus.score_l, bus.score_r}, 0);
        check("mid_rst_game_over", bus.game_over, 0);
        @(posedge clk);
        @(posedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
